// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative radix-2 restoring divider: state encodings and
// handshake levels.
package div_iter_pkg;

    typedef enum logic [1:0] {
        DivIdle   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // Range of result_o at the current 32-bit core width.
    localparam int unsigned DoubleRegBusMsb = 63;
    localparam int unsigned DoubleRegBusLsb = 0;

endpackage

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock, signed/unsigned.
// Optional macro DIV_ZERO_FLAG_EN adds div_zero_o to tag divide-by-zero results.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  cancel_i,
`ifdef DIV_ZERO_FLAG_EN
    output logic                  div_zero_o,
`endif
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    div_state_e            r_state;
    div_state_e            w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_dividend;
    logic [DATA_W-1:0]     r_divisor;
    logic [DATA_W-1:0]     r_rem;
    logic                  r_quo_sign;
    logic                  r_rem_sign;
    logic                  r_ready;
    logic [2*DATA_W-1:0]   r_result;

    logic                  w_op1_neg;
    logic                  w_op2_neg;
    logic [DATA_W-1:0]     w_op1_abs;
    logic [DATA_W-1:0]     w_op2_abs;
    logic [DATA_W:0]       w_shift;
    logic [DATA_W:0]       w_sub;
    logic                  w_fits;
    logic [DATA_W-1:0]     w_rem_next;
    logic [DATA_W-1:0]     w_quo_next;
    logic [DATA_W-1:0]     w_quo_fix;
    logic [DATA_W-1:0]     w_rem_fix;
    logic                  w_last;

    assign w_op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign w_op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign w_op1_abs = w_op1_neg ? -opdata1_i : opdata1_i;
    assign w_op2_abs = w_op2_neg ? -opdata2_i : opdata2_i;

    // Partial remainder stays below the divisor, so the top bit of the (DATA_W+1)-bit
    // difference is set exactly when the trial subtract goes negative.
    assign w_shift    = {r_rem, r_dividend[DATA_W-1]};
    assign w_sub      = w_shift - {1'b0, r_divisor};
    assign w_fits     = ~w_sub[DATA_W];
    assign w_rem_next = w_fits ? w_sub[DATA_W-1:0] : w_shift[DATA_W-1:0];
    assign w_quo_next = {r_dividend[DATA_W-2:0], w_fits};
    assign w_quo_fix  = r_quo_sign ? -w_quo_next : w_quo_next;
    assign w_rem_fix  = r_rem_sign ? -w_rem_next : w_rem_next;
    assign w_last     = (r_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DivIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (cancel_i) begin
            w_state_next = DivIdle;
        end else begin
            unique case (r_state)
                DivIdle: begin
                    if (start_i == DivStart) begin
                        w_state_next = (opdata2_i == '0) ? DivByZero : DivOn;
                    end
                end
                DivByZero: w_state_next = DivEnd;
                DivOn: begin
                    if (w_last) begin
                        w_state_next = DivEnd;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        w_state_next = DivIdle;
                    end
                end
                default: w_state_next = DivIdle;
            endcase
        end
    end

    always_comb begin
        busy_o   = (r_state != DivIdle);
        ready_o  = r_ready;
        result_o = r_result;
    end

`ifdef DIV_ZERO_FLAG_EN
    logic r_div_zero;

    assign div_zero_o = r_div_zero & r_ready;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quo_sign <= 1'b0;
            r_rem_sign <= 1'b0;
            r_ready    <= DivResultNotReady;
            r_result   <= '0;
`ifdef DIV_ZERO_FLAG_EN
            r_div_zero <= 1'b0;
`endif
        end else if (cancel_i) begin
            // Abort keeps the last published result.
            r_ready <= DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
            r_div_zero <= 1'b0;
`endif
        end else begin
            case (r_state)
                DivIdle: begin
                    r_ready <= DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
                    r_div_zero <= 1'b0;
`endif
                    if (start_i == DivStart) begin
                        r_cnt      <= '0;
                        r_rem      <= '0;
                        r_quo_sign <= w_op1_neg ^ w_op2_neg;
                        r_rem_sign <= w_op1_neg;
                        if (opdata2_i == '0) begin
                            r_dividend <= opdata1_i;
                            r_divisor  <= '0;
                        end else begin
                            r_dividend <= w_op1_abs;
                            r_divisor  <= w_op2_abs;
                        end
                    end
                end
                DivByZero: begin
                    r_result <= {r_dividend, {DATA_W{1'b1}}};
`ifdef DIV_ZERO_FLAG_EN
                    r_div_zero <= 1'b1;
`endif
                end
                DivOn: begin
                    r_rem      <= w_rem_next;
                    r_dividend <= w_quo_next;
                    r_cnt      <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result <= {w_rem_fix, w_quo_fix};
                    end
                end
                DivEnd: begin
                    // Ready rises on the first edge spent in END and drops when start goes.
                    r_ready <= (start_i == DivStart) ? DivResultReady : DivResultNotReady;
                end
                default: r_ready <= DivResultNotReady;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter at DATA_W=32.
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        cancel_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;
`ifdef DIV_ZERO_FLAG_EN
    logic        div_zero_o;
`endif

    int n_checks;
    int n_fail;

    div_iter #(
        .DATA_W(32)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .cancel_i     (cancel_i),
`ifdef DIV_ZERO_FLAG_EN
        .div_zero_o   (div_zero_o),
`endif
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request, scramble operands after the sampling edge, wait for ready.
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res,
                           input int exp_lat, input logic exp_dz);
        int lat;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        opdata1_i = ~a;
        opdata2_i = b ^ 32'h0000_0005;
        signed_div_i = ~sgn;
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy after start: got %b want 1", name, busy_o);
        end
        lat = 0;
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (ready_o === 1'b1) lat = n;
        end
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d (0 = timeout)", name, lat, exp_lat);
        end
        n_checks++;
        if (result_o !== exp_res) begin
            n_fail++;
            $display("FAIL %s result: got %h want %h", name, result_o, exp_res);
        end
`ifdef DIV_ZERO_FLAG_EN
        n_checks++;
        if (div_zero_o !== exp_dz) begin
            n_fail++;
            $display("FAIL %s div_zero_o: got %b want %b", name, div_zero_o, exp_dz);
        end
`else
        if (exp_dz === 1'bx) $display("unexpected flag value in %s", name);
`endif
        // Start still held: must stay in END with a stable result.
        @(posedge clk);
        #1;
        n_checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b1 || result_o !== exp_res) begin
            n_fail++;
            $display("FAIL %s hold in END: got rdy=%b busy=%b res=%h want 1 1 %h",
                     name, ready_o, busy_o, result_o, exp_res);
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== exp_res) begin
            n_fail++;
            $display("FAIL %s return to idle: got rdy=%b busy=%b res=%h want 0 0 %h",
                     name, ready_o, busy_o, result_o, exp_res);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        cancel_i     = 1'b0;
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (result_o !== 64'h0) begin
            n_fail++;
            $display("FAIL reset result: got %h want 0", result_o);
        end
        n_checks++;
        if (ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset ready: got %b want 0", ready_o);
        end
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset busy: got %b want 0", busy_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_unsigned();
        run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33, 1'b0);
        run_div("uFFF9_2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'h1, 32'h7FFF_FFFC}, 33, 1'b0);
        run_div("uFFFF_10", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33, 1'b0);
    endtask

    task automatic test_signed();
        run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b0);
        run_div("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 33, 1'b0);
    endtask

    task automatic test_div_zero();
        run_div("divz", 1'b0, 32'h1234_5678, 32'h0, {32'h1234_5678, 32'hFFFF_FFFF}, 2, 1'b1);
        run_div("divz_s", 1'b1, 32'h8000_0001, 32'h0, {32'h8000_0001, 32'hFFFF_FFFF}, 2, 1'b1);
    endtask

    task automatic test_overflow();
        run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 1'b0);
    endtask

    task automatic test_cancel();
        int seen;
        run_div("pre_cancel", 1'b0, 32'd50, 32'd6, {32'h2, 32'h8}, 33, 1'b0);
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        cancel_i = 1'b1;
        start_i  = 1'b0;
        @(posedge clk);
        #1;
        cancel_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== {32'h2, 32'h8}) begin
            n_fail++;
            $display("FAIL cancel to idle: got busy=%b rdy=%b res=%h want 0 0 %h",
                     busy_o, ready_o, result_o, {32'h2, 32'h8});
        end
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b0 || busy_o !== 1'b0) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL cancel stays idle: got %0d active samples want 0", seen);
        end
        // cancel and start together in IDLE must not launch
        @(negedge clk);
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        cancel_i  = 1'b1;
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        cancel_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel beats start: got busy=%b want 0", busy_o);
        end
        repeat (2) @(posedge clk);
        run_div("post_cancel", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33, 1'b0);
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (result_o !== 64'h0 || ready_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset mid-op: got res=%h rdy=%b busy=%b want 0 0 0",
                     result_o, ready_o, busy_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (ready_o === 1'b1) lat = n;
        end
        n_checks++;
        if (lat !== 33 || result_o !== {32'h2, 32'hE}) begin
            n_fail++;
            $display("FAIL after reset: got lat=%0d res=%h want 33 %h",
                     lat, result_o, {32'h2, 32'hE});
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        run_div("b2b_a", 1'b0, 32'd1000, 32'd3, {32'h1, 32'd333}, 33, 1'b0);
        run_div("b2b_b", 1'b1, 32'hFFFF_FC18, 32'd10, {32'h0, 32'hFFFF_FF9C}, 33, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
